// File: rtl/grf_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_wport_arbiter_pkg
// Brief    : Shared constants and helpers for the GRF write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package grf_wport_arbiter_pkg;

    // Register address width and the hardwired-zero register.
    localparam int                REG_AW   = 5;
    localparam int                NUM_REGS = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // One-hot register mask for a destination address.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_AW-1:0] a3);
        reg_bit     = '0;
        reg_bit[a3] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grf_wport_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : grf_wport_arbiter_fifo
// Brief    : Circular queue of pending aux writes with a per-entry live bit,
//            parallel cancel-by-register and a live destination mask.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wport_arbiter_fifo
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic                i_push_live,
    input  logic [REG_AW-1:0]   i_push_a3,
    input  logic [DW-1:0]       i_push_wd,
    input  logic [DW-1:0]       i_push_pc,
    input  logic                i_pop,
    input  logic                i_cancel,
    input  logic [REG_AW-1:0]   i_cancel_a3,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_head_live,
    output logic [REG_AW-1:0]   o_head_a3,
    output logic [DW-1:0]       o_head_wd,
    output logic [DW-1:0]       o_head_pc,
    output logic [NUM_REGS-1:0] o_live_mask
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_live;
    logic [REG_AW-1:0] r_a3 [DEPTH];
    logic [DW-1:0]     r_wd [DEPTH];
    logic [DW-1:0]     r_pc [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Live bits: a freed slot is always dead, so the mask never sees stale entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wptr == PW'(i)))
                    r_live[i] <= i_push_live;
                else if (i_pop && (r_rptr == PW'(i)))
                    r_live[i] <= 1'b0;
                else if (i_cancel && (r_a3[i] == i_cancel_a3))
                    r_live[i] <= 1'b0;
            end
        end
    end

    // Payload storage; contents are meaningless while the live bit is clear.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_a3[r_wptr] <= i_push_a3;
            r_wd[r_wptr] <= i_push_wd;
            r_pc[r_wptr] <= i_push_pc;
        end
    end

    // Destination mask of every still-live queued write.
    always_comb begin
        o_live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) o_live_mask = o_live_mask | reg_bit(r_a3[i]);
        end
    end

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == (PW+1)'(DEPTH));
    assign o_head_live = r_live[r_rptr];
    assign o_head_a3   = r_a3[r_rptr];
    assign o_head_wd   = r_wd[r_rptr];
    assign o_head_pc   = r_pc[r_rptr];

endmodule
`default_nettype wire

// File: rtl/grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_wport_arbiter
// Brief    : Shares the GRF write port between WB (fixed priority) and a
//            queued aux producer; cancels superseded aux writes, exports a
//            pending-write mask and a starvation stall request.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wport_arbiter
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int DW         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_a3,
    input  logic [DW-1:0]       wb_wd,
    input  logic [DW-1:0]       wb_pc,
    input  logic                aux_valid,
    output logic                aux_ready,
    input  logic [REG_AW-1:0]   aux_a3,
    input  logic [DW-1:0]       aux_wd,
    input  logic [DW-1:0]       aux_pc,
    output logic                grf_we,
    output logic [REG_AW-1:0]   grf_a3,
    output logic [DW-1:0]       grf_wd,
    output logic [DW-1:0]       grf_pc,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                stall_req
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                r_rst_q;
    logic [SW-1:0]       r_starve;
    logic                r_stall;

    logic                w_hold;
    logic                w_wb_busy;
    logic                w_ready;
    logic                w_push;
    logic                w_push_live;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic                w_head_live;
    logic [REG_AW-1:0]   w_head_a3;
    logic [DW-1:0]       w_head_wd;
    logic [DW-1:0]       w_head_pc;
    logic [NUM_REGS-1:0] w_live_mask;

    // Outputs stay quiet during reset and for one cycle after it drops.
    assign w_hold      = reset | r_rst_q;
    assign w_wb_busy   = !w_hold && wb_we && (wb_a3 != ZERO_REG);
    assign w_ready     = !w_hold && !w_full;
    // Writes to $0 complete the handshake but are never stored.
    assign w_push      = aux_valid && w_ready && (aux_a3 != ZERO_REG);
    // A same-cycle WB write to the same register is newer, so the entry starts dead.
    assign w_push_live = !(w_wb_busy && (wb_a3 == aux_a3));
    // Dead heads are discarded whenever present; live heads only in a free slot.
    assign w_pop       = !w_hold && !w_empty && (!w_head_live || !w_wb_busy);

    grf_wport_arbiter_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_live (w_push_live),
        .i_push_a3   (aux_a3),
        .i_push_wd   (aux_wd),
        .i_push_pc   (aux_pc),
        .i_pop       (w_pop),
        .i_cancel    (w_wb_busy),
        .i_cancel_a3 (wb_a3),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_head_live (w_head_live),
        .o_head_a3   (w_head_a3),
        .o_head_wd   (w_head_wd),
        .o_head_pc   (w_head_pc),
        .o_live_mask (w_live_mask)
    );

    // Write-slot mux: WB first, then a live queue head, otherwise idle zeros.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (w_wb_busy) begin
            grf_we = 1'b1;
            grf_a3 = wb_a3;
            grf_wd = wb_wd;
            grf_pc = wb_pc;
        end else if (w_pop && w_head_live) begin
            grf_we = 1'b1;
            grf_a3 = w_head_a3;
            grf_wd = w_head_wd;
            grf_pc = w_head_pc;
        end
    end

    // Delayed reset used to keep outputs quiet the cycle after reset.
    always_ff @(posedge clk) begin
        r_rst_q <= reset;
    end

    // Starvation counter and sticky stall request, released by the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_empty || w_pop)
                r_starve <= '0;
            else if (w_head_live && (r_starve != SW'(STARVE_MAX)))
                r_starve <= r_starve + 1'b1;
            r_stall <= !w_pop && (r_stall ||
                       (!w_empty && w_head_live && (r_starve == SW'(STARVE_MAX - 1))));
        end
    end

    assign aux_ready = w_ready;
    assign busy_mask = w_hold ? '0 : w_live_mask;
    assign stall_req = r_stall && !reset;

endmodule
`default_nettype wire

// File: tb/tb_grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wport_arbiter
// Brief    : Scoreboard bench for grf_wport_arbiter with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wport_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int DW         = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_we;
    logic [4:0]    wb_a3;
    logic [DW-1:0] wb_wd;
    logic [DW-1:0] wb_pc;
    logic          aux_valid;
    logic          aux_ready;
    logic [4:0]    aux_a3;
    logic [DW-1:0] aux_wd;
    logic [DW-1:0] aux_pc;
    logic          grf_we;
    logic [4:0]    grf_a3;
    logic [DW-1:0] grf_wd;
    logic [DW-1:0] grf_pc;
    logic [31:0]   busy_mask;
    logic          stall_req;

    always #5 clk = ~clk;

    grf_wport_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .DW         (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .wb_pc     (wb_pc),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_a3    (aux_a3),
        .aux_wd    (aux_wd),
        .aux_pc    (aux_pc),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc),
        .busy_mask (busy_mask),
        .stall_req (stall_req)
    );

    typedef struct packed {
        logic          live;
        logic [4:0]    a3;
        logic [DW-1:0] wd;
        logic [DW-1:0] pc;
    } ent_t;

    // Reference model state: pending aux writes in program order.
    ent_t mq[$];
    ent_t q_exp[$];
    int   starve;
    bit   m_stall;
    bit   prev_rst;

    // Expected per-cycle values published by the model for the monitor.
    bit          e_ready, e_we, e_stall, e_wb, e_drop;
    logic [31:0] e_busy;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model evaluation for the current inputs (before the clock edge).
    task automatic model_eval();
        bit hold;
        hold    = reset || prev_rst;
        e_ready = !hold && (mq.size() < DEPTH);
        e_busy  = '0;
        if (!hold)
            foreach (mq[i]) if (mq[i].live) e_busy[mq[i].a3] = 1'b1;
        e_stall = m_stall && !reset;
        e_wb    = !hold && wb_we && (wb_a3 != 5'd0);
        // The oldest entry leaves if it is dead, or if it is live and the slot is free.
        e_drop  = !hold && (mq.size() > 0) && (!mq[0].live || !e_wb);
        e_we    = 1'b0;
        if (e_wb) begin
            e_we = 1'b1;
            q_exp.push_back({1'b1, wb_a3, wb_wd, wb_pc});
        end else if (e_drop && mq[0].live) begin
            e_we = 1'b1;
            q_exp.push_back(mq[0]);
        end
    endtask

    // Model state advance at the clock edge, using the inputs of that cycle.
    task automatic model_update();
        if (reset) begin
            mq.delete();
            starve  = 0;
            m_stall = 1'b0;
        end else if (!(prev_rst)) begin
            m_stall = !e_drop && (m_stall ||
                      (mq.size() > 0 && starve == STARVE_MAX - 1));
            if (mq.size() == 0 || e_drop) starve = 0;
            else if (starve < STARVE_MAX)  starve++;
            if (e_drop) void'(mq.pop_front());
            if (e_wb)
                foreach (mq[i]) if (mq[i].a3 == wb_a3) mq[i].live = 1'b0;
            if (aux_valid && e_ready && aux_a3 != 5'd0)
                mq.push_back({!(e_wb && wb_a3 == aux_a3), aux_a3, aux_wd, aux_pc});
        end
        prev_rst = reset;
    endtask

    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [DW-1:0] wwd, input logic av,
                         input logic [4:0] aa, input logic [DW-1:0] awd);
        reset     = rst;
        wb_we     = we;
        wb_a3     = wa;
        wb_wd     = wwd;
        wb_pc     = $urandom;
        aux_valid = av;
        aux_a3    = aa;
        aux_wd    = awd;
        aux_pc    = $urandom;
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    // Monitor: compare status every cycle, pop the scoreboard on each GRF write.
    always @(negedge clk) begin
        if (run) begin
            ent_t e;
            chk("aux_ready", {95'd0, aux_ready}, {95'd0, e_ready});
            chk("busy_mask", {64'd0, busy_mask}, {64'd0, e_busy});
            chk("stall_req", {95'd0, stall_req}, {95'd0, e_stall});
            chk("grf_we",    {95'd0, grf_we},    {95'd0, e_we});
            if (grf_we) begin
                if (q_exp.size() == 0) begin
                    chk("grf_write_unexpected", {grf_a3, grf_wd, grf_pc}, 96'hx);
                end else begin
                    e = q_exp.pop_front();
                    chk("grf_write", {27'd0, grf_a3, grf_wd, grf_pc},
                        {27'd0, e.a3, e.wd, e.pc});
                end
            end else begin
                chk("grf_idle_zero", {27'd0, grf_a3, grf_wd, grf_pc}, 96'd0);
                if (e_we && q_exp.size() > 0) void'(q_exp.pop_front());
            end
        end
    end

    initial begin
        int k;
        starve   = 0;
        m_stall  = 1'b0;
        prev_rst = 1'b0;
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        run = 1'b1;
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        idle(2);

        // 1: single aux write through an idle slot
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h1234);
        idle(2);

        // 2: starvation behind continuous WB writes
        cycle(1'b0, 1'b1, 5'd3, $urandom, 1'b1, 5'd7, $urandom);
        k = 0;
        while (!stall_req && k < 20) begin
            cycle(1'b0, 1'b1, 5'd3, $urandom, 1'b0, 5'd0, '0);
            k++;
        end
        chk("starve_wait_cycles", 96'(k), 96'(STARVE_MAX));
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        idle(2);

        // 3: WB supersedes a pending aux write, same cycle and next
        cycle(1'b0, 1'b1, 5'd9, 32'hBBBB, 1'b1, 5'd9, 32'hAAAA);
        cycle(1'b0, 1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, '0);
        idle(2);

        // 4: fill the queue, then one pop re-opens it a cycle later
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b1, 5'd3, $urandom, 1'b1, 5'(10 + i), $urandom);
        cycle(1'b0, 1'b1, 5'd3, $urandom, 1'b1, 5'd20, $urandom);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd21, $urandom);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd22, $urandom);
        idle(DEPTH + 2);

        // 5: reset discards queued writes
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 5'd3, $urandom, 1'b1, 5'(24 + i), $urandom);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        idle(4);

        // 6: aux write to $0 is accepted and dropped
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hDEAD);
        idle(2);

        // Random traffic, small register range to exercise cancellation
        for (int i = 0; i < 3000; i++) begin
            logic we;
            we = ($urandom_range(0, 99) < 55) && !m_stall;
            cycle(($urandom_range(0, 199) == 0), we, 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(DEPTH + STARVE_MAX + 4);

        chk("scoreboard_drained", 96'(q_exp.size()), 96'd0);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
